// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the MEM pipeline stage:
// data-memory FSM state encoding, EX/MEM control bit positions and the
// default datapath width.
package mem_stage_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int CTRL_W     = 8;

   // EXMEM_ctrl = {HALT, MemWrite, MemRead, LBI_sel, MemToReg, PCtoReg, RegWrite, STU}
   localparam int CTRL_HALT     = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_LBI_SEL  = 4;
   localparam int CTRL_MEMTOREG = 3;
   localparam int CTRL_PCTOREG  = 2;
   localparam int CTRL_REGWRITE = 1;
   localparam int CTRL_STU      = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } dmem_state_t;

   // A HALT never touches memory even if its read/write bits are set.
   function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
      return (ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE]) & ~ctrl[CTRL_HALT];
   endfunction

endpackage

// File: rtl/dmem_ctrl_fsm.sv
// dmem_ctrl_fsm -- sequences one data-memory access per memory
// instruction: IDLE -> ACCESS (wait for dmem_done) -> DONE -> IDLE.
// dmem_done is only honoured in ACCESS; the pipeline stall is forced low
// while reset is asserted.
module dmem_ctrl_fsm
   import mem_stage_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic mem_op,
   input  logic dmem_done,
   output logic dmem_req,
   output logic stall,
   output logic capture
);

   dmem_state_t state_r;
   dmem_state_t next_s;
   logic        stall_s;

   // State register; reset returns to IDLE immediately, even mid-access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state and per-state outputs.
   always_comb begin
      next_s   = state_r;
      dmem_req = 1'b0;
      stall_s  = 1'b0;
      capture  = 1'b0;
      case (state_r)
         IDLE: begin
            if (mem_op) begin
               stall_s = 1'b1;
               next_s  = ACCESS;
            end else begin
               next_s  = IDLE;
            end
         end
         ACCESS: begin
            dmem_req = 1'b1;
            stall_s  = 1'b1;
            if (dmem_done) begin
               capture = 1'b1;
               next_s  = DONE;
            end else begin
               next_s  = ACCESS;
            end
         end
         DONE: begin
            next_s = IDLE;
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   assign stall = stall_s & ~rst;

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: data-memory handshake (via
// dmem_ctrl_fsm), read-data capture, writeback-data select and the MEM/WB
// pipeline register. MEM/WB holds whenever Stall_DM is high.
// Optional build macro DMEM_ALIGN_CHK_EN: memory ops to odd addresses are
// suppressed and flagged on MEMWB_err with the register write cancelled.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] EXMEM_ALUResult,
   input  logic [DATA_W-1:0] EXMEM_read2DataOut,
   input  logic [7:0]        EXMEM_ctrl,
   input  logic [2:0]        EXMEM_IDEX_writeRegSel,
   input  logic [DATA_W-1:0] EXMEM_IDEX_i8SE,
   input  logic [DATA_W-1:0] EXMEM_IDEX_IFID_PC_inc,
   output logic              dmem_req,
   output logic              dmem_wr,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_done,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              Stall_DM,
   output logic [DATA_W-1:0] MEMWB_wb_data,
   output logic              MEMWB_RegWrite,
   output logic [2:0]        MEMWB_writeRegSel,
   output logic              MEMWB_HALT,
   output logic              MEMWB_err,
   output logic [DATA_W-1:0] MEM_WB_fwd_data
);

   logic              mem_op_raw_s;
   logic              misalign_s;
   logic              mem_op_s;
   logic              capture_s;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] wb_data_s;

   assign mem_op_raw_s = is_mem_op(EXMEM_ctrl);

`ifdef DMEM_ALIGN_CHK_EN
   assign misalign_s = mem_op_raw_s & EXMEM_ALUResult[0];
`else
   assign misalign_s = 1'b0;
`endif

   // A misaligned op is treated as a plain pass-through instruction.
   assign mem_op_s = mem_op_raw_s & ~misalign_s;

   dmem_ctrl_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .mem_op    (mem_op_s),
      .dmem_done (dmem_done),
      .dmem_req  (dmem_req),
      .stall     (Stall_DM),
      .capture   (capture_s)
   );

   // EX/MEM is frozen during the stall, so the request fields stay stable.
   assign dmem_wr    = dmem_req & EXMEM_ctrl[CTRL_MEMWRITE];
   assign dmem_addr  = EXMEM_ALUResult;
   assign dmem_wdata = EXMEM_read2DataOut;

   // Capture read data on the completing ACCESS cycle only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= {DATA_W{1'b0}};
      end else if (capture_s) begin
         rdata_q <= dmem_rdata;
      end else begin
         rdata_q <= rdata_q;
      end
   end

   // Writeback select; a store-update always writes back the ALU result.
   always_comb begin
      wb_data_s = EXMEM_ALUResult;
      if (EXMEM_ctrl[CTRL_PCTOREG]) begin
         wb_data_s = EXMEM_IDEX_IFID_PC_inc;
      end else if (EXMEM_ctrl[CTRL_LBI_SEL]) begin
         wb_data_s = EXMEM_IDEX_i8SE;
      end else if (EXMEM_ctrl[CTRL_MEMTOREG] & ~EXMEM_ctrl[CTRL_STU]) begin
         wb_data_s = rdata_q;
      end else begin
         wb_data_s = EXMEM_ALUResult;
      end
   end

   // MEM/WB pipeline register; loads whenever the stage is not stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         MEMWB_wb_data     <= {DATA_W{1'b0}};
         MEMWB_RegWrite    <= 1'b0;
         MEMWB_writeRegSel <= 3'd0;
         MEMWB_HALT        <= 1'b0;
         MEMWB_err         <= 1'b0;
      end else if (!Stall_DM) begin
         MEMWB_wb_data     <= wb_data_s;
         MEMWB_RegWrite    <= EXMEM_ctrl[CTRL_REGWRITE] & ~misalign_s;
         MEMWB_writeRegSel <= EXMEM_IDEX_writeRegSel;
         MEMWB_HALT        <= EXMEM_ctrl[CTRL_HALT];
         MEMWB_err         <= misalign_s;
      end else begin
         MEMWB_wb_data     <= MEMWB_wb_data;
         MEMWB_RegWrite    <= MEMWB_RegWrite;
         MEMWB_writeRegSel <= MEMWB_writeRegSel;
         MEMWB_HALT        <= MEMWB_HALT;
         MEMWB_err         <= MEMWB_err;
      end
   end

   assign MEM_WB_fwd_data = MEMWB_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- scoreboard bench for mem_stage. Each instruction pushes
// its expected MEM/WB contents and stall length; they are popped and
// compared once the stage releases the instruction to writeback.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] EXMEM_ALUResult;
   logic [15:0] EXMEM_read2DataOut;
   logic [7:0]  EXMEM_ctrl;
   logic [2:0]  EXMEM_IDEX_writeRegSel;
   logic [15:0] EXMEM_IDEX_i8SE;
   logic [15:0] EXMEM_IDEX_IFID_PC_inc;
   logic        dmem_req, dmem_wr, dmem_done;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        Stall_DM;
   logic [15:0] MEMWB_wb_data, MEM_WB_fwd_data;
   logic        MEMWB_RegWrite, MEMWB_HALT, MEMWB_err;
   logic [2:0]  MEMWB_writeRegSel;

   mem_stage #(.DATA_W(16)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .EXMEM_ALUResult        (EXMEM_ALUResult),
      .EXMEM_read2DataOut     (EXMEM_read2DataOut),
      .EXMEM_ctrl             (EXMEM_ctrl),
      .EXMEM_IDEX_writeRegSel (EXMEM_IDEX_writeRegSel),
      .EXMEM_IDEX_i8SE        (EXMEM_IDEX_i8SE),
      .EXMEM_IDEX_IFID_PC_inc (EXMEM_IDEX_IFID_PC_inc),
      .dmem_req               (dmem_req),
      .dmem_wr                (dmem_wr),
      .dmem_addr              (dmem_addr),
      .dmem_wdata             (dmem_wdata),
      .dmem_done              (dmem_done),
      .dmem_rdata             (dmem_rdata),
      .Stall_DM               (Stall_DM),
      .MEMWB_wb_data          (MEMWB_wb_data),
      .MEMWB_RegWrite         (MEMWB_RegWrite),
      .MEMWB_writeRegSel      (MEMWB_writeRegSel),
      .MEMWB_HALT             (MEMWB_HALT),
      .MEMWB_err              (MEMWB_err),
      .MEM_WB_fwd_data        (MEM_WB_fwd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] wb;
      logic        rw;
      logic [2:0]  sel;
      logic        halt;
      logic        err;
      int          stall;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_rdata_q;
   logic [15:0] last_wb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Call right after a rising edge (#1): drives one EX/MEM instruction,
   // plays memory for it and checks what lands in MEM/WB.
   task automatic run_instr(input string tag, input logic [15:0] alu, input logic [15:0] st,
                            input logic [7:0] ctrl, input logic [2:0] sel,
                            input logic [15:0] i8, input logic [15:0] pcinc,
                            input int done_after, input logic [15:0] rdata);
      exp_t e, g;
      logic memop, mis;
      int   stall_cnt, acc;
      bit   finished;
      EXMEM_ALUResult        = alu;
      EXMEM_read2DataOut     = st;
      EXMEM_ctrl             = ctrl;
      EXMEM_IDEX_writeRegSel = sel;
      EXMEM_IDEX_i8SE        = i8;
      EXMEM_IDEX_IFID_PC_inc = pcinc;
      dmem_done              = 1'b0;
      dmem_rdata             = ~rdata;
      memop = (ctrl[6] | ctrl[5]) & ~ctrl[7];
      mis   = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
      mis   = memop & alu[0];
`endif
      if (mis) memop = 1'b0;
      if (memop) m_rdata_q = rdata;
      e.stall = memop ? done_after + 1 : 0;
      e.acc   = memop ? done_after : 0;
      if (ctrl[2])                 e.wb = pcinc;
      else if (ctrl[4])            e.wb = i8;
      else if (ctrl[3] & ~ctrl[0]) e.wb = m_rdata_q;
      else                         e.wb = alu;
      e.rw   = ctrl[1] & ~mis;
      e.sel  = sel;
      e.halt = ctrl[7];
      e.err  = mis;
      sb_q.push_back(e);

      stall_cnt = 0;
      acc       = 0;
      finished  = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         dmem_done  = 1'b0;
         dmem_rdata = ~rdata;
         if (Stall_DM) begin
            stall_cnt++;
            if (stall_cnt == 1) check({tag, ".hold"}, MEMWB_wb_data, last_wb);
         end
         if (dmem_req) begin
            acc++;
            if (acc == 1) begin
               check({tag, ".wr"},    dmem_wr,    ctrl[6]);
               check({tag, ".addr"},  dmem_addr,  alu);
               check({tag, ".wdata"}, dmem_wdata, st);
            end
            if (acc == done_after) begin
               dmem_done  = 1'b1;
               dmem_rdata = rdata;
            end
         end
         if (!Stall_DM) begin
            check({tag, ".req_idle"}, dmem_req, 1'b0);
            finished = 1'b1;
            break;
         end
      end
      if (!finished) check({tag, ".timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      dmem_done = 1'b0;
      g = sb_q.pop_front();
      check({tag, ".wb"},    MEMWB_wb_data,     g.wb);
      check({tag, ".fwd"},   MEM_WB_fwd_data,   g.wb);
      check({tag, ".rw"},    MEMWB_RegWrite,    g.rw);
      check({tag, ".sel"},   MEMWB_writeRegSel, g.sel);
      check({tag, ".halt"},  MEMWB_HALT,        g.halt);
      check({tag, ".err"},   MEMWB_err,         g.err);
      check({tag, ".stall"}, stall_cnt,         g.stall);
      check({tag, ".acc"},   acc,               g.acc);
      last_wb = g.wb;
   endtask

   task automatic check_memwb_zero(input string tag);
      check({tag, ".wb0"},   MEMWB_wb_data,     16'h0000);
      check({tag, ".rw0"},   MEMWB_RegWrite,    1'b0);
      check({tag, ".sel0"},  MEMWB_writeRegSel, 3'd0);
      check({tag, ".halt0"}, MEMWB_HALT,        1'b0);
      check({tag, ".err0"},  MEMWB_err,         1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      // Reset with a load sitting in EX/MEM: no stall, no request.
      rst                    = 1'b1;
      EXMEM_ALUResult        = 16'h0040;
      EXMEM_read2DataOut     = 16'h0000;
      EXMEM_ctrl             = 8'b0010_1010;
      EXMEM_IDEX_writeRegSel = 3'd2;
      EXMEM_IDEX_i8SE        = 16'h0000;
      EXMEM_IDEX_IFID_PC_inc = 16'h0000;
      dmem_done              = 1'b0;
      dmem_rdata             = 16'h0000;
      m_rdata_q              = 16'h0000;
      last_wb                = 16'h0000;
      #1;
      check("rst.req",   dmem_req, 1'b0);
      check("rst.stall", Stall_DM, 1'b0);
      check_memwb_zero("rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      run_instr("add",    16'h1234, 16'h0000, 8'b0000_0010, 3'd3, 16'h0000, 16'h0000, 0, 16'h0000);
      run_instr("load",   16'h0040, 16'h0000, 8'b0010_1010, 3'd5, 16'h0000, 16'h0000, 3, 16'hBEEF);
      run_instr("store",  16'h0010, 16'h00AA, 8'b0100_0000, 3'd0, 16'h0000, 16'h0000, 1, 16'h1111);
      run_instr("ld_b2b1",16'h0020, 16'h0000, 8'b0010_1010, 3'd1, 16'h0000, 16'h0000, 2, 16'hCAFE);
      run_instr("ld_b2b2",16'h0022, 16'h0000, 8'b0010_1010, 3'd6, 16'h0000, 16'h0000, 1, 16'h5A5A);
      run_instr("lbi",    16'h0999, 16'h0000, 8'b0001_1010, 3'd4, 16'hFF80, 16'h0000, 0, 16'h0000);
      run_instr("link",   16'h0999, 16'h0000, 8'b0001_0110, 3'd7, 16'hFF80, 16'h0102, 0, 16'h0000);
      run_instr("stu",    16'h0030, 16'h4321, 8'b0100_0011, 3'd2, 16'h0000, 16'h0000, 2, 16'h2222);
      run_instr("halt",   16'h0050, 16'h0000, 8'b1010_0000, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000);
      run_instr("odd",    16'h0041, 16'h0000, 8'b0010_1010, 3'd3, 16'h0000, 16'h0000, 1, 16'h7777);

      // Spurious dmem_done in IDLE must not stall or capture.
      EXMEM_ctrl = 8'b0000_0000;
      @(negedge clk);
      dmem_done  = 1'b1;
      dmem_rdata = 16'hDEAD;
      #1;
      check("spur.stall", Stall_DM, 1'b0);
      check("spur.req",   dmem_req, 1'b0);
      @(posedge clk);
      #1;
      dmem_done = 1'b0;
      last_wb   = MEMWB_wb_data;
      run_instr("spur_rd", 16'h0AAA, 16'h0000, 8'b0000_1010, 3'd1, 16'h0000, 16'h0000, 0, 16'h0000);

      // Reset in the middle of an access.
      EXMEM_ALUResult = 16'h0060;
      EXMEM_ctrl      = 8'b0010_1010;
      dmem_done       = 1'b0;
      seen            = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (dmem_req) begin
            seen = 1'b1;
            break;
         end
      end
      check("rstmid.access", seen, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid.req",   dmem_req, 1'b0);
      check("rstmid.stall", Stall_DM, 1'b0);
      check_memwb_zero("rstmid");
      @(posedge clk);
      #1;
      rst       = 1'b0;
      m_rdata_q = 16'h0000;
      last_wb   = 16'h0000;
      sb_q.delete();
      run_instr("post_add", 16'h0777, 16'h0000, 8'b0000_0010, 3'd5, 16'h0000, 16'h0000, 0, 16'h0000);
      run_instr("post_rdq", 16'h0888, 16'h0000, 8'b0000_1010, 3'd6, 16'h0000, 16'h0000, 0, 16'h0000);
      run_instr("post_ld",  16'h0100, 16'h0000, 8'b0010_1010, 3'd2, 16'h0000, 16'h0000, 2, 16'h3C3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width of all address, data and writeback buses.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port EXMEM_ALUResult, input, DATA_W, memory address / ALU result from the EX/MEM register.
REQ-005 SHALL have port EXMEM_read2DataOut, input, DATA_W, store data.
REQ-006 SHALL have port EXMEM_ctrl, input, 8, packed {HALT, MemWrite, MemRead, LBI_sel, MemToReg, PCtoReg, RegWrite, STU}, MSB first.
REQ-007 SHALL have port EXMEM_IDEX_writeRegSel, input, 3, destination register.
REQ-008 SHALL have port EXMEM_IDEX_i8SE, input, DATA_W, sign-extended immediate for LBI.
REQ-009 SHALL have port EXMEM_IDEX_IFID_PC_inc, input, DATA_W, PC+2 for link writes.
REQ-010 SHALL have port dmem_req, output, 1, memory access request.
REQ-011 SHALL have port dmem_wr, output, 1, 1 = write, 0 = read; valid while dmem_req = 1.
REQ-012 SHALL have port dmem_addr, output, DATA_W, access address.
REQ-013 SHALL have port dmem_wdata, output, DATA_W, write data.
REQ-014 SHALL have port dmem_done, input, 1, access complete; dmem_rdata valid in the same cycle.
REQ-015 SHALL have port dmem_rdata, input, DATA_W, read data.
REQ-016 SHALL have port Stall_DM, output, 1, freezes EX/MEM and all upstream stages.
REQ-017 SHALL have outputs MEMWB_wb_data (DATA_W), MEMWB_RegWrite (1), MEMWB_writeRegSel (3), MEMWB_HALT (1) and MEMWB_err (1), all registered toward writeback.
REQ-018 SHALL have port MEM_WB_fwd_data, output, DATA_W, equal to MEMWB_wb_data.

Function
REQ-019 FSM SHALL have three states: IDLE, ACCESS, DONE.
- Memory op = (MemRead | MemWrite) & ~HALT.
REQ-020 IDLE, no memory op: Stall_DM = 0; MEM/WB loads at the next edge (1-cycle latency).
REQ-021 IDLE, memory op: Stall_DM = 1; next state is ACCESS.
REQ-022 ACCESS: dmem_req = 1, Stall_DM = 1; dmem_wr = MemWrite, dmem_addr = EXMEM_ALUResult, dmem_wdata = EXMEM_read2DataOut, all held stable until dmem_done.
REQ-023 ACCESS with dmem_done = 1: dmem_rdata SHALL be captured into rdata_q; next state is DONE. Without dmem_done, the FSM stays in ACCESS indefinitely.
REQ-024 DONE: Stall_DM = 0 and dmem_req = 0; MEM/WB loads; next state is IDLE unconditionally.
- Minimum memory-op stall is 2 cycles.
REQ-025 MEM/WB SHALL hold its value in every cycle where Stall_DM = 1.
REQ-026 wb_data priority SHALL be: PCtoReg ? PC_inc : LBI_sel ? i8SE : MemToReg ? rdata_q : ALUResult.
- A store-update (STU) writes ALUResult.
REQ-027 dmem_done outside ACCESS SHALL be ignored.
REQ-028 Back-to-back memory ops SHALL each perform a full IDLE→ACCESS→DONE sequence, with no overlap.
REQ-029 A HALT instruction SHALL issue no memory access; MEMWB_HALT = 1 after its normal 1-cycle pass.
REQ-030 dmem_req SHALL never be asserted in IDLE or DONE.

Reset
REQ-031 rst = 1 SHALL force IDLE, clear rdata_q, and clear all MEMWB_* outputs to 0, asynchronously, including mid-ACCESS.
- dmem_req SHALL drop to 0 immediately, and Stall_DM = 0 while rst = 1.

Configuration
REQ-032 Macro DMEM_ALIGN_CHK_EN: when defined, a memory op with EXMEM_ALUResult[0] = 1 SHALL NOT enter ACCESS.
- It is handled as a non-memory op (Stall_DM = 0), with MEMWB_err = 1 and MEMWB_RegWrite forced to 0.
- When undefined, MEMWB_err SHALL be tied to 0 and odd addresses issued unchanged.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the EXMEM_ctrl bit-index constants and the DATA_W default.
REQ-034 The FSM SHALL be a sub-module dmem_ctrl_fsm; MEM/WB registers and the wb_data mux stay in mem_stage.

Verification
REQ-035 ADD result 0x1234, RegWrite = 1, reg 3 -> next cycle MEMWB_wb_data = 0x1234, writeRegSel = 3, Stall_DM never 1.
REQ-036 Load at 0x0040, dmem_done after 3 ACCESS cycles with rdata 0xBEEF -> Stall_DM high 4 cycles, then MEMWB_wb_data = 0xBEEF.
REQ-037 Store 0x00AA to 0x0010, done on the first ACCESS cycle -> one dmem_req pulse with wr = 1, addr 0x0010, wdata 0x00AA; 2-cycle stall.
REQ-038 rst pulsed during ACCESS -> dmem_req = 0 and MEMWB_* = 0 immediately; FSM in IDLE after release.
REQ-039 With DMEM_ALIGN_CHK_EN, load at 0x0041 -> no dmem_req, MEMWB_err = 1, MEMWB_RegWrite = 0.
REQ-040 Spurious dmem_done in IDLE -> no state change, no capture.
